// File: rtl/slot_vfu_request_queue.sv
// In-order request queue between the slot-request arbiter and the VFU, with a per-tag busy bitmap.
// Optional zero-latency bypass for an empty queue when SLOT_VFU_QUEUE_BYPASS_EN is defined.
module slot_vfu_request_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 2,
    parameter int unsigned REQ_W = 86
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [REQ_W-1:0]         in_bits,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [REQ_W-1:0]         out_bits,
    input  logic                     resp_valid,
    input  logic [TAG_W-1:0]         resp_tag,
    input  logic                     flush,
    output logic [(1<<TAG_W)-1:0]    busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     resp_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned NT = 1 << TAG_W;
    localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);
    localparam logic [AW:0] PtrOne   = (AW+1)'(1);

    logic [REQ_W-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [NT-1:0]    busy_q, busy_d;
    logic             resp_err_q, resp_err_d;

    logic [REQ_W-1:0] head;
    logic [TAG_W-1:0] head_tag;
    logic [TAG_W-1:0] issue_tag;
    logic             empty;
    logic             full;
    logic             head_valid;
    logic             enq;
    logic             deq;
    logic             issue;

    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign head_tag = head[TAG_W-1:0];
    assign empty    = (count_q == '0);
    assign full     = (count_q == DepthCnt);

    assign in_ready   = !full && !flush;
    // A busy head tag stalls the whole queue; younger entries never overtake it.
    assign head_valid = !empty && !busy_q[head_tag] && !flush;

`ifdef SLOT_VFU_QUEUE_BYPASS_EN
    logic [TAG_W-1:0] in_tag;
    logic             bypass;

    assign in_tag    = in_bits[TAG_W-1:0];
    assign bypass    = empty && in_valid && !flush && !busy_q[in_tag];
    assign out_valid = head_valid || bypass;
    assign out_bits  = bypass ? in_bits : head;
    // A bypassed request that issues immediately never touches the FIFO.
    assign enq       = in_valid && in_ready && !(bypass && out_ready);
    assign issue_tag = bypass ? in_tag : head_tag;
`else
    assign out_valid = head_valid;
    assign out_bits  = head;
    assign enq       = in_valid && in_ready;
    assign issue_tag = head_tag;
`endif

    assign deq   = head_valid && out_ready;
    assign issue = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            unique case ({enq, deq})
                2'b10:   count_d = count_q + PtrOne;
                2'b01:   count_d = count_q - PtrOne;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        busy_d     = busy_q;
        resp_err_d = resp_err_q;
        if (resp_valid) begin
            busy_d[resp_tag] = 1'b0;
            if (!busy_q[resp_tag]) begin
                resp_err_d = 1'b1;
            end
        end
        // Issue only happens for a non-busy tag, so set after clear is safe.
        if (issue) begin
            busy_d[issue_tag] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            busy_q     <= '0;
            resp_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            resp_err_q <= resp_err_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (enq) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_bits;
        end
    end

    assign busy     = busy_q;
    assign count    = count_q;
    assign resp_err = resp_err_q;

endmodule
